// File: rtl/pc_gen_pkg.sv
// rtl/pc_gen_pkg.sv - shared state type and default vectors for the program-counter generator
package pc_pkg;

    localparam int          PC_XLEN_DEFAULT         = 32;
    localparam int          PC_INSTR_BYTES_DEFAULT  = 4;
    localparam logic [31:0] PC_RESET_VECTOR_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_TRAP_VECTOR_DEFAULT  = 32'h0000_0100;

    typedef enum logic [1:0] {
        PC_BOOT   = 2'd0,
        PC_RUN    = 2'd1,
        PC_HALTED = 2'd2
    } pc_state_t;

    // Number of low address bits that must be zero for an aligned fetch.
    function automatic int pc_align_bits(input int instr_bytes);
        return $clog2(instr_bytes);
    endfunction

endpackage

// File: rtl/pc_gen_if.sv
// rtl/pc_gen_if.sv - fetch handshake, redirect and halt signals between the pc generator and the IF stage
interface pc_gen_if #(
    parameter int XLEN = 32
);

    logic            fetch_ready;
    logic            redirect_en;
    logic [XLEN-1:0] redirect_target;
    logic            trap_req;
    logic            halt_req;
    logic [XLEN-1:0] pc_out;
    logic            pc_valid;
    logic [XLEN-1:0] pc_plus;
    logic            misalign_err;
    logic            halted;

    modport master (
        input  fetch_ready,
        input  redirect_en,
        input  redirect_target,
        input  trap_req,
        input  halt_req,
        output pc_out,
        output pc_valid,
        output pc_plus,
        output misalign_err,
        output halted
    );

    modport slave (
        output fetch_ready,
        output redirect_en,
        output redirect_target,
        output trap_req,
        output halt_req,
        input  pc_out,
        input  pc_valid,
        input  pc_plus,
        input  misalign_err,
        input  halted
    );

endinterface

// File: rtl/pc_gen_align_chk.sv
// rtl/pc_gen_align_chk.sv - flags a redirect target whose low alignment bits are not zero
module pc_align_chk #(
    parameter int XLEN        = 32,
    parameter int INSTR_BYTES = 4
) (
    input  logic [XLEN-1:0] target,
    output logic            misaligned
);

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INSTR_BYTES - 1);

    always_comb begin
        misaligned = |(target & ALIGN_MASK);
    end

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - program-counter generator with fetch handshake, redirect/trap steering and halt control
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN         = PC_XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(PC_RESET_VECTOR_DEFAULT),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(PC_TRAP_VECTOR_DEFAULT),
    parameter int              INSTR_BYTES  = PC_INSTR_BYTES_DEFAULT
) (
    input  logic     clk,
    input  logic     reset,
    pc_gen_if.master bus
);

    localparam int              ALIGN_BITS = pc_align_bits(INSTR_BYTES);
    localparam logic [XLEN-1:0] STEP       = XLEN'(INSTR_BYTES);

    generate
        if (INSTR_BYTES < 2 || (INSTR_BYTES & (INSTR_BYTES - 1)) != 0) begin : g_bad_step
            $error("pc_gen: INSTR_BYTES must be a power of two and at least 2");
        end
        if ((RESET_VECTOR & (STEP - XLEN'(1))) != '0 || (TRAP_VECTOR & (STEP - XLEN'(1))) != '0) begin : g_bad_vec
            $error("pc_gen: RESET_VECTOR and TRAP_VECTOR must be aligned to INSTR_BYTES");
        end
        if (ALIGN_BITS >= XLEN) begin : g_bad_width
            $error("pc_gen: INSTR_BYTES too large for XLEN");
        end
    endgenerate

    pc_state_t       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            misalign_q, misalign_d;

    logic            pc_valid;
    logic            accept;
    logic            redirect_live;
    logic            target_misaligned;
    logic [XLEN-1:0] pc_plus;

    pc_align_chk #(
        .XLEN        (XLEN),
        .INSTR_BYTES (INSTR_BYTES)
    ) u_align_chk (
        .target     (bus.redirect_target),
        .misaligned (target_misaligned)
    );

    always_comb begin
        pc_valid      = (state_q == PC_RUN);
        accept        = pc_valid && bus.fetch_ready;
        pc_plus       = pc_q + STEP;
        redirect_live = bus.redirect_en && (state_q != PC_HALTED);
    end

    // Next-pc priority: trap, then redirect (flushes any accept), then sequential advance, else hold.
    always_comb begin
        pc_d       = pc_q;
        misalign_d = 1'b0;
        if (bus.trap_req) begin
            pc_d = TRAP_VECTOR;
        end else if (redirect_live) begin
            if (target_misaligned) begin
                pc_d       = TRAP_VECTOR;
                misalign_d = 1'b1;
            end else begin
                pc_d = bus.redirect_target;
            end
        end else if (accept) begin
            pc_d = pc_plus;
        end
    end

    // An unaccepted request stays on the bus until the IF stage takes it, so halting waits for ready.
    always_comb begin
        state_d = state_q;
        case (state_q)
            PC_BOOT:   state_d = bus.halt_req ? PC_HALTED : PC_RUN;
            PC_RUN:    state_d = (bus.halt_req && (bus.fetch_ready || !pc_valid)) ? PC_HALTED : PC_RUN;
            PC_HALTED: state_d = bus.halt_req ? PC_HALTED : PC_RUN;
            default:   state_d = PC_BOOT;
        endcase
        if (bus.trap_req) begin
            state_d = PC_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= PC_BOOT;
            pc_q       <= RESET_VECTOR;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    assign bus.pc_out       = pc_q;
    assign bus.pc_valid     = pc_valid;
    assign bus.pc_plus      = pc_plus;
    assign bus.misalign_err = misalign_q;
    assign bus.halted       = (state_q == PC_HALTED);

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - scoreboard bench for pc_gen with directed scenarios and random stimulus
module tb_pc_gen;

    localparam logic [31:0] RV   = 32'h0000_0000;
    localparam logic [31:0] TV   = 32'h0000_0100;
    localparam int          M_BOOT = 0, M_RUN = 1, M_HALT = 2;

    typedef struct {
        logic [31:0] pc;
        logic        valid;
        logic [31:0] plus;
        logic        mis;
        logic        halted;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    pc_gen_if #(.XLEN(32)) bus ();

    pc_gen #(
        .XLEN         (32),
        .RESET_VECTOR (RV),
        .TRAP_VECTOR  (TV),
        .INSTR_BYTES  (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t        sbq[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] m_pc   = 32'h0;
    int          m_mode = M_BOOT;
    logic        m_mis  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: apply one clock edge of the documented rules, then queue the visible outputs.
    task automatic step(input bit r, input bit rdy, input bit rd, input logic [31:0] tgt,
                        input bit tr, input bit hl);
        bit   was_valid;
        exp_t e;
        @(negedge clk);
        reset               = r;
        bus.fetch_ready     = rdy;
        bus.redirect_en     = rd;
        bus.redirect_target = tgt;
        bus.trap_req        = tr;
        bus.halt_req        = hl;
        if (r) begin
            m_pc   = RV;
            m_mode = M_BOOT;
            m_mis  = 1'b0;
        end else begin
            was_valid = (m_mode == M_RUN);
            m_mis     = 1'b0;
            if (tr)
                m_pc = TV;
            else if (rd && m_mode != M_HALT) begin
                if (tgt % 4 != 0) begin
                    m_pc  = TV;
                    m_mis = 1'b1;
                end else
                    m_pc = tgt;
            end else if (was_valid && rdy)
                m_pc = m_pc + 32'd4;
            if (tr)
                m_mode = M_RUN;
            else if (m_mode == M_RUN)
                m_mode = (hl && rdy) ? M_HALT : M_RUN;
            else
                m_mode = hl ? M_HALT : M_RUN;
        end
        e.pc     = m_pc;
        e.valid  = (m_mode == M_RUN);
        e.plus   = m_pc + 32'd4;
        e.mis    = m_mis;
        e.halted = (m_mode == M_HALT);
        sbq.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check("pc_out",       bus.pc_out,              e.pc);
                check("pc_valid",     {31'b0, bus.pc_valid},     {31'b0, e.valid});
                check("pc_plus",      bus.pc_plus,             e.plus);
                check("misalign_err", {31'b0, bus.misalign_err}, {31'b0, e.mis});
                check("halted",       {31'b0, bus.halted},       {31'b0, e.halted});
            end
        end
    end

    initial begin : stimulus
        bit          hl;
        logic [31:0] tgt;
        bus.fetch_ready     = 1'b0;
        bus.redirect_en     = 1'b0;
        bus.redirect_target = 32'h0;
        bus.trap_req        = 1'b0;
        bus.halt_req        = 1'b0;

        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);

        step(0, 1, 1, 32'h0000_0200, 0, 0);
        step(0, 1, 1, 32'h0000_0202, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        step(0, 1, 1, 32'h0000_0300, 1, 0);
        step(0, 0, 1, 32'h0000_0302, 1, 0);
        step(1, 1, 1, 32'h0000_0300, 1, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);

        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 1);
        step(0, 1, 1, 32'h0000_0400, 0, 1);
        step(0, 1, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);

        step(0, 0, 1, 32'hFFFF_FFFC, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);

        hl = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) hl = ~hl;
            tgt = $urandom();
            if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
            if ($urandom_range(0, 15) == 0) tgt = 32'hFFFF_FFF8 + 32'($urandom_range(0, 1) * 4);
            step(($urandom_range(0, 63) == 0), $urandom_range(0, 1), ($urandom_range(0, 7) == 0), tgt,
                 (!hl && $urandom_range(0, 15) == 0), hl);
        end

        step(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
